// File: rtl/membus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Used by membus_arb and membus_pick; see membus_arb.sv for MEMBUS_ARB_RR_EN.
package membus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic OWN_DBG = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  function automatic logic other_owner(input logic own);
    return (own == OWN_DBG) ? OWN_CPU : OWN_DBG;
  endfunction

endpackage

// File: rtl/membus_pick.sv
// Combinational winner selection between the debug and CPU masters.
// MEMBUS_ARB_RR_EN selects round-robin on ties; otherwise debug always wins.
module membus_pick
  import membus_pkg::*;
(
  input  logic dbg_eff_i,
  input  logic cpu_eff_i,
`ifdef MEMBUS_ARB_RR_EN
  input  logic last_i,
`endif
  output logic grant_valid_o,
  output logic grant_owner_o
);

  always_comb begin
    grant_valid_o = dbg_eff_i | cpu_eff_i;
    grant_owner_o = OWN_DBG;
`ifdef MEMBUS_ARB_RR_EN
    // On a tie the master that was not served last takes the bus.
    if (dbg_eff_i && cpu_eff_i) begin
      grant_owner_o = other_owner(last_i);
    end else if (cpu_eff_i) begin
      grant_owner_o = OWN_CPU;
    end
`else
    if (!dbg_eff_i && cpu_eff_i) begin
      grant_owner_o = OWN_CPU;
    end
`endif
  end

endmodule

// File: rtl/membus_arb.sv
// Two-master shared memory bus arbiter: registered address phase, then data phase.
// Define MEMBUS_ARB_RR_EN for round-robin tie breaking (adds the 'last' register).
module membus_arb
  import membus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                dbg_req,
  input  logic [DATA_W/8-1:0] dbg_wren,
  input  logic [ADDR_W-1:0]   dbg_adr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_ack,
  output logic [DATA_W-1:0]   dbg_rdata,

  input  logic                cpu_en,
  input  logic                cpu_req,
  input  logic [DATA_W/8-1:0] cpu_wren,
  input  logic [ADDR_W-1:0]   cpu_adr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_hlt,

  output logic                mem_op,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [DATA_W-1:0]   mem_di,
  output logic [DATA_W/8-1:0] mem_wren,
  input  logic [DATA_W-1:0]   mem_do,

  output logic                owner
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_ADDR = ST_ADDR;
  localparam logic [1:0] S_DATA = ST_DATA;

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [ADDR_W-1:0] adr_q,       adr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [BE_W-1:0]   wren_q,      wren_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
`ifdef MEMBUS_ARB_RR_EN
  logic              last_q,      last_d;
`endif

  logic dbg_eff;
  logic cpu_eff;
  logic grant_valid;
  logic grant_owner;
  logic in_addr;
  logic in_data;
  logic cmd_read;

  assign dbg_eff  = dbg_req;
  assign cpu_eff  = cpu_req & cpu_en;
  assign in_addr  = (state_q == S_ADDR);
  assign in_data  = (state_q == S_DATA);
  assign cmd_read = (wren_q == '0);

  membus_pick u_pick (
    .dbg_eff_i     (dbg_eff),
    .cpu_eff_i     (cpu_eff),
`ifdef MEMBUS_ARB_RR_EN
    .last_i        (last_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // The command is frozen at grant; later request changes are ignored until IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    wren_d      = wren_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef MEMBUS_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWN_CPU) begin
            adr_d   = cpu_adr;
            wdata_d = cpu_wdata;
            wren_d  = cpu_wren;
          end else begin
            adr_d   = dbg_adr;
            wdata_d = dbg_wdata;
            wren_d  = dbg_wren;
          end
`ifdef MEMBUS_ARB_RR_EN
          last_d  = grant_owner;
`endif
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cmd_read) begin
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_do;
          end else begin
            dbg_rdata_d = mem_do;
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DBG;
      adr_q       <= '0;
      wdata_q     <= '0;
      wren_q      <= '0;
      dbg_rdata_q <= '0;
      cpu_rdata_q <= '0;
`ifdef MEMBUS_ARB_RR_EN
      last_q      <= OWN_CPU;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef MEMBUS_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Read data is forwarded from the bus during the ack cycle, then held in the register.
  assign dbg_ack   = in_data & (owner_q == OWN_DBG);
  assign cpu_ack   = in_data & (owner_q == OWN_CPU);
  assign dbg_rdata = (dbg_ack && cmd_read) ? mem_do : dbg_rdata_q;
  assign cpu_rdata = (cpu_ack && cmd_read) ? mem_do : cpu_rdata_q;
  assign cpu_hlt   = cpu_req & cpu_en & ~cpu_ack;

  assign mem_op    = in_addr;
  assign mem_adr   = adr_q;
  assign mem_di    = wdata_q;
  assign mem_wren  = in_addr ? wren_q : '0;
  assign owner     = owner_q;

endmodule

// File: tb/tb_membus_arb.sv
// Scoreboard bench for membus_arb: expected acks are queued at stimulus and popped on ack.
// Expected ordering follows MEMBUS_ARB_RR_EN when the bench is built with it.
module tb_membus_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_req;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        cpu_en;
  logic        cpu_req;
  logic [3:0]  cpu_wren;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_hlt;
  logic        mem_op;
  logic [31:0] mem_adr;
  logic [31:0] mem_di;
  logic [3:0]  mem_wren;
  logic [31:0] memDo = 32'h0;
  logic        owner;

  membus_arb dut (
    .clk       (clk),
    .reset     (reset),
    .dbg_req   (dbg_req),
    .dbg_wren  (dbg_wren),
    .dbg_adr   (dbg_adr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .cpu_en    (cpu_en),
    .cpu_req   (cpu_req),
    .cpu_wren  (cpu_wren),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_hlt   (cpu_hlt),
    .mem_op    (mem_op),
    .mem_adr   (mem_adr),
    .mem_di    (mem_di),
    .mem_wren  (mem_wren),
    .mem_do    (memDo),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } expect_t;

  int          compareCount  = 0;
  int          mismatchCount = 0;
  int          cycleCount    = 0;
  int          dbgAckCycle   = -1;
  int          cpuAckCycle   = -1;
  int          startCycle;
  int          wrenCycles;
  int          hltCycles;
  int          memOpCycles[$];
  bit          monitorOn = 1'b0;
  bit          gotAck;
  expect_t     expQ[$];
  expect_t     monExp;
  logic [31:0] expDbgRdata = 32'h0;
  logic [31:0] expCpuRdata = 32'h0;

  // Memory contents seen by the bench: one fixed word plus an address-derived pattern.
  function automatic logic [31:0] memModel(input logic [31:0] adr);
    if (adr == 32'h0002_0004) return 32'hDEAD_BEEF;
    return {~adr[15:0], adr[15:0]};
  endfunction

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(posedge clk)
    memDo <= (mem_op === 1'b1 && mem_wren == 4'h0) ? memModel(mem_adr) : 32'h0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d",
               tag, observed, expected, cycleCount);
    end
  endtask

  // Queue the ack a master should receive; writes leave that master's rdata unchanged.
  task automatic pushExpect(input logic own, input logic [3:0] wren, input logic [31:0] adr);
    expect_t e;
    if (wren == 4'h0) begin
      if (own) expCpuRdata = memModel(adr);
      else     expDbgRdata = memModel(adr);
    end
    e.owner = own;
    e.rdata = own ? expCpuRdata : expDbgRdata;
    expQ.push_back(e);
  endtask

  // Called at posedge+1; drives one transaction, waits for its ack, returns at posedge+1.
  task automatic applyStimulus(input bit isCpu, input logic [3:0] wren,
                               input logic [31:0] adr, input logic [31:0] wdata,
                               input bit keepReq);
    bit got;
    got = 1'b0;
    if (isCpu) begin
      cpu_req = 1'b1; cpu_wren = wren; cpu_adr = adr; cpu_wdata = wdata;
    end else begin
      dbg_req = 1'b1; dbg_wren = wren; dbg_adr = adr; dbg_wdata = wdata;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((isCpu ? cpu_ack : dbg_ack) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(isCpu ? "cpuAckTimeout" : "dbgAckTimeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (!keepReq) begin
      if (isCpu) cpu_req = 1'b0;
      else       dbg_req = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      if (dbg_ack === 1'b1 && cpu_ack === 1'b1) checkOutput("dualAck", 64'd1, 64'd0);
      if (mem_op === 1'b1) memOpCycles.push_back(cycleCount);
      if (dbg_ack === 1'b1 || cpu_ack === 1'b1) begin
        if (cpu_ack === 1'b1) cpuAckCycle = cycleCount;
        else                  dbgAckCycle = cycleCount;
        if (expQ.size() == 0) begin
          checkOutput("sbUnexpectedAck", 64'd1, 64'd0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("sbOwner", 64'(cpu_ack === 1'b1), 64'(monExp.owner));
          checkOutput("sbRdata", 64'((cpu_ack === 1'b1) ? cpu_rdata : dbg_rdata),
                      64'(monExp.rdata));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    dbg_req = 1'b0; dbg_wren = 4'h0; dbg_adr = 32'h0; dbg_wdata = 32'h0;
    cpu_en  = 1'b1; cpu_req  = 1'b0; cpu_wren = 4'h0; cpu_adr = 32'h0; cpu_wdata = 32'h0;
    $display("[TB] membus_arb bench starting");

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstMemOp",    64'(mem_op),    64'd0);
    checkOutput("rstMemWren",  64'(mem_wren),  64'd0);
    checkOutput("rstDbgAck",   64'(dbg_ack),   64'd0);
    checkOutput("rstCpuAck",   64'(cpu_ack),   64'd0);
    checkOutput("rstDbgRdata", 64'(dbg_rdata), 64'd0);
    checkOutput("rstCpuRdata", 64'(cpu_rdata), 64'd0);
    checkOutput("rstOwner",    64'(owner),     64'd0);
    checkOutput("rstHlt",      64'(cpu_hlt),   64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    monitorOn = 1'b1;

    // Single debug read with exact phase timing.
    pushExpect(1'b0, 4'h0, 32'h0002_0004);
    dbg_req = 1'b1; dbg_wren = 4'h0; dbg_adr = 32'h0002_0004;
    @(negedge clk);
    checkOutput("t2PreMemOp", 64'(mem_op), 64'd0);
    @(negedge clk);
    checkOutput("t2MemOp",   64'(mem_op),   64'd1);
    checkOutput("t2MemAdr",  64'(mem_adr),  64'h0002_0004);
    checkOutput("t2MemWren", 64'(mem_wren), 64'd0);
    checkOutput("t2Owner",   64'(owner),    64'd0);
    @(negedge clk);
    checkOutput("t2MemOpLow", 64'(mem_op),    64'd0);
    checkOutput("t2DbgAck",   64'(dbg_ack),   64'd1);
    checkOutput("t2Rdata",    64'(dbg_rdata), 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    @(negedge clk);
    checkOutput("t2AckPulse",  64'(dbg_ack),   64'd0);
    checkOutput("t2RdataHeld", 64'(dbg_rdata), 64'hDEAD_BEEF);

    // CPU read, then a full-word CPU write that must not disturb cpu_rdata.
    @(posedge clk);
    #1;
    pushExpect(1'b1, 4'h0, 32'h0000_0040);
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0);
    pushExpect(1'b1, 4'hF, 32'h0000_0010);
    wrenCycles = 0;
    hltCycles  = 0;
    fork
      applyStimulus(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b0);
      begin
        repeat (8) begin
          @(negedge clk);
          if (mem_wren == 4'hF) wrenCycles++;
          if (cpu_hlt === 1'b1) hltCycles++;
          if (mem_op === 1'b1) begin
            checkOutput("t3MemAdr", 64'(mem_adr), 64'h10);
            checkOutput("t3MemDi",  64'(mem_di),  64'h1234_5678);
          end
        end
      end
    join
    checkOutput("t3WrenCycles", 64'(wrenCycles), 64'd1);
    checkOutput("t3HltCycles",  64'(hltCycles),  64'd2);
    checkOutput("t3RdataKept",  64'(cpu_rdata),  64'(memModel(32'h40)));

    // Simultaneous requests: debug served first, CPU waits a full transaction.
    @(posedge clk);
    #1;
    pushExpect(1'b0, 4'h0, 32'h0000_0080);
    pushExpect(1'b1, 4'h0, 32'h0000_0090);
    startCycle = cycleCount;
    fork
      applyStimulus(1'b0, 4'h0, 32'h0000_0080, 32'h0, 1'b0);
      applyStimulus(1'b1, 4'h0, 32'h0000_0090, 32'h0, 1'b0);
    join
    checkOutput("t4DbgAckCycle", 64'(dbgAckCycle - startCycle), 64'd2);
    checkOutput("t4CpuAckCycle", 64'(cpuAckCycle - startCycle), 64'd5);

    // Both masters hold req across two transactions each.
`ifdef MEMBUS_ARB_RR_EN
    pushExpect(1'b0, 4'h0, 32'h0000_0100);
    pushExpect(1'b1, 4'h0, 32'h0000_0200);
    pushExpect(1'b0, 4'h0, 32'h0000_0104);
    pushExpect(1'b1, 4'h0, 32'h0000_0204);
`else
    pushExpect(1'b0, 4'h0, 32'h0000_0100);
    pushExpect(1'b0, 4'h0, 32'h0000_0104);
    pushExpect(1'b1, 4'h0, 32'h0000_0200);
    pushExpect(1'b1, 4'h0, 32'h0000_0204);
`endif
    fork
      begin
        applyStimulus(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b0);
      end
      begin
        applyStimulus(1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0204, 32'h0, 1'b0);
      end
    join
    checkOutput("t5QueueDrained", 64'(expQ.size()), 64'd0);

    // CPU request masked while cpu_en is low, granted once enabled.
    cpu_en = 1'b0; cpu_req = 1'b1; cpu_wren = 4'h0; cpu_adr = 32'h0000_0300;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t6NoGrant", 64'(mem_op),  64'd0);
      checkOutput("t6HltLow",  64'(cpu_hlt), 64'd0);
    end
    pushExpect(1'b1, 4'h0, 32'h0000_0300);
    @(posedge clk);
    #1;
    cpu_en = 1'b1;
    @(negedge clk);
    checkOutput("t6HltHigh",     64'(cpu_hlt), 64'd1);
    checkOutput("t6MemOpNotYet", 64'(mem_op),  64'd0);
    @(negedge clk);
    checkOutput("t6Grant",  64'(mem_op),  64'd1);
    checkOutput("t6Owner",  64'(owner),   64'd1);
    checkOutput("t6MemAdr", 64'(mem_adr), 64'h300);
    @(negedge clk);
    checkOutput("t6Ack", 64'(cpu_ack), 64'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;

    // Reset hits the address phase of a CPU read; the held request is served afterwards.
    cpu_req = 1'b1; cpu_adr = 32'h0000_0304;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t7InAddr", 64'(mem_op), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t7MemOp",     64'(mem_op),    64'd0);
    checkOutput("t7CpuAck",    64'(cpu_ack),   64'd0);
    checkOutput("t7DbgAck",    64'(dbg_ack),   64'd0);
    checkOutput("t7CpuRdata",  64'(cpu_rdata), 64'd0);
    checkOutput("t7DbgRdata",  64'(dbg_rdata), 64'd0);
    checkOutput("t7Owner",     64'(owner),     64'd0);
    checkOutput("t7MemWren",   64'(mem_wren),  64'd0);
    expDbgRdata = 32'h0;
    expCpuRdata = 32'h0;
    pushExpect(1'b1, 4'h0, 32'h0000_0304);
    @(posedge clk);
    #1;
    reset = 1'b0;
    gotAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        gotAck = 1'b1;
        break;
      end
    end
    checkOutput("t7Reserved", 64'(gotAck), 64'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;

    // cpu_en dropping mid-transaction does not abort it.
    pushExpect(1'b1, 4'h0, 32'h0000_0308);
    cpu_req = 1'b1; cpu_adr = 32'h0000_0308;
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
    gotAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        gotAck = 1'b1;
        break;
      end
    end
    checkOutput("t8AckDespiteEn", 64'(gotAck), 64'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_en  = 1'b1;

    // Debug holds req across its ack: a write then a read, address phases 3 cycles apart.
    pushExpect(1'b0, 4'b0011, 32'h0000_0050);
    pushExpect(1'b0, 4'h0,    32'h0000_0060);
    memOpCycles.delete();
    applyStimulus(1'b0, 4'b0011, 32'h0000_0050, 32'hA5A5_5A5A, 1'b1);
    applyStimulus(1'b0, 4'h0,    32'h0000_0060, 32'h0,         1'b0);
    checkOutput("t9MemOpCount", 64'(memOpCycles.size()), 64'd2);
    if (memOpCycles.size() == 2)
      checkOutput("t9MemOpSpacing", 64'(memOpCycles[1] - memOpCycles[0]), 64'd3);

    repeat (3) @(negedge clk);
    checkOutput("sbDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/membus_arb.md
# membus_arb

Two-master arbiter for the shared SoC memory bus (RAM, MMIO, ROM data port). It replaces ad-hoc muxing between the debug unit and the CPU data port. It sequences each access as a registered address phase followed by a data phase, matching the one-cycle read latency of the block RAMs. It also generates the CPU stall so the core waits on contention or memory latency.

## Interface
- `ADDR_W`, 32: bus address width
- `DATA_W`, 32: bus data width (byte-enable width = DATA_W/8)
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `dbg_req` in 1: debug unit requests a transaction; held until `dbg_ack`
- `dbg_wren` in 4: byte write enables; 0 = read
- `dbg_adr` in ADDR_W: byte address
- `dbg_wdata` in DATA_W: write data
- `dbg_ack` out 1: one-cycle completion pulse
- `dbg_rdata` out DATA_W: read data, valid while `dbg_ack`=1 and held afterwards
- `cpu_en` in 1: CPU running; when 0, `cpu_req` is masked
- `cpu_req`, `cpu_wren`, `cpu_adr`, `cpu_wdata`, `cpu_ack`, `cpu_rdata`: same as the dbg set, for the CPU data port
- `cpu_hlt` out 1: stall to CPU; = `cpu_req & cpu_en & ~cpu_ack` (combinational)
- `mem_op` out 1: bus select strobe to the address decoder
- `mem_adr` out ADDR_W, `mem_di` out DATA_W, `mem_wren` out 4: registered bus command
- `mem_do` in DATA_W: OR-combined read bus, valid in the cycle after `mem_op`
- `owner` out 1: 0 = dbg, 1 = cpu; the current or last grant

## Operation
- FSM states: IDLE, ADDR, DATA. Encoding comes from the package.
- **IDLE**
  - No effective request: stay in IDLE.
  - Otherwise, the picker chooses a winner.
  - Capture the winner's adr, wdata and wren into the command registers and set `owner`.
  - Go to ADDR.
- **ADDR**
  - `mem_op`=1; `mem_adr`, `mem_di` and `mem_wren` come from the registers.
  - Always go to DATA.
- **DATA**
  - `mem_op`=0; `mem_wren` is cleared.
  - Pulse the owner's ack.
  - If the command was a read (wren==0), capture `mem_do` into the owner's rdata register. On writes the rdata register keeps its previous value.
  - Always go to IDLE.
- Effective requests: `dbg_req`, and `cpu_req & cpu_en`.
- Masters hold req and command stable until ack. A master that keeps req high after its ack issues a new transaction.
- Default policy is fixed priority: dbg beats cpu when both request. CPU starvation is acceptable because the debugger halts the CPU before bulk access.
- Inputs that change during ADDR/DATA are ignored. The command is latched at grant.
- `cpu_en` dropping during an in-flight CPU transaction does not abort it. The transaction completes and `cpu_ack` still pulses.
- Reset in any state:
  - next state IDLE
  - `mem_op`, `mem_wren`, acks = 0
  - rdata registers = 0, `owner` = 0
  - command registers = 0
  - An interrupted transaction produces no ack.

## Timing
- Request sampled high in IDLE at edge N:
  - `mem_op`=1 during cycle N+1
  - ack=1 and rdata valid during cycle N+2
  - IDLE in cycle N+3
- Minimum 3 cycles per transaction. Back-to-back throughput is one access per 3 cycles.
- A loser waits for the full winner transaction: its ack arrives at N+5 at the earliest.
- `cpu_hlt` rises in the same cycle as `cpu_req` and falls in the `cpu_ack` cycle.
- Exactly one ack per grant. Both acks are never high in the same cycle.

## Configuration
- `MEMBUS_ARB_RR_EN` defined:
  - Round-robin. A `last` register records the previous winner.
  - On simultaneous requests, the master not served last wins.
  - `last` resets to cpu, so the first tie goes to dbg.
- Not defined: fixed dbg-first priority, and no `last` register is built.

## Structure
- Package `membus_pkg`:
  - state enum (IDLE/ADDR/DATA)
  - owner encoding (`OWN_DBG`=0, `OWN_CPU`=1)
  - default widths
- Sub-module `membus_pick`:
  - combinational winner selection from effective requests (plus `last` under the macro)
  - outputs `grant_valid` and `grant_owner`
- The FSM, command registers, rdata registers and `last` register live in `membus_arb`.

## Test plan
- Single dbg read, adr=0x20004, `mem_do`=0xDEADBEEF in cycle N+2:
  - `mem_op` high only in N+1 with `mem_adr`=0x20004, `mem_wren`=0
  - `dbg_ack` in N+2 with `dbg_rdata`=0xDEADBEEF
- CPU write, adr=0x00010, wdata=0x12345678, wren=0xF:
  - `mem_wren`=0xF for exactly one cycle
  - `cpu_hlt` high for 2 cycles
  - `cpu_rdata` unchanged
- Simultaneous dbg and cpu requests:
  - without macro: dbg acked at N+2, cpu at N+5
  - with `MEMBUS_ARB_RR_EN` and both holding req for 4 transactions: acks alternate dbg, cpu, dbg, cpu
- `cpu_en`=0 with `cpu_req`=1:
  - no grant, `cpu_hlt`=0
  - raising `cpu_en` produces a grant at the next IDLE sample
- Reset asserted during ADDR of a cpu read:
  - next cycle `mem_op`=0, no `cpu_ack`, all rdata=0, state IDLE
  - the pending request is re-served after reset is released
- dbg holding req across its ack:
  - second transaction starts 3 cycles after the first
  - `mem_op` pulses are 3 cycles apart
